// File: rtl/hazard_controller.sv
// Pipeline hazard unit: load-use stalls, branch flushes, data-memory freeze and EX operand forwarding.
// Outputs are combinational from shadow state; shadows track the pipeline one cycle behind ID.
module hazard_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_branch_taken,
    input  logic             dmem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             freeze,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [6:0] OP_LTYPE = 7'b0000011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_STYPE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BTYPE = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JTYPE = 7'b1101111;

    localparam logic [1:0] MUX_REG = 2'd0;
    localparam logic [1:0] MUX_MEM = 2'd1;
    localparam logic [1:0] MUX_WB  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       load;
        logic       mem;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
    } ex_shadow_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       load;
        logic       mem;
    } mem_shadow_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
    } wb_shadow_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    ex_shadow_t  ex_q;
    ex_shadow_t  id_dec;
    ex_shadow_t  ex_nxt;
    mem_shadow_t mem_q;
    wb_shadow_t  wb_q;
    state_t      state;
    state_t      state_nxt;

    logic load_use;
    logic branch_act;
    logic load_use_act;

    // Unknown opcodes (including ERROR) leave every flag clear and behave as a NOP.
    always_comb begin
        id_dec = '0;
        case (id_opcode)
            OP_LTYPE: begin
                id_dec.wr   = 1'b1;
                id_dec.load = 1'b1;
                id_dec.mem  = 1'b1;
                id_dec.u1   = 1'b1;
            end
            OP_ITYPE, OP_JALR: begin
                id_dec.wr = 1'b1;
                id_dec.u1 = 1'b1;
            end
            OP_AUIPC, OP_LUI, OP_JTYPE: begin
                id_dec.wr = 1'b1;
            end
            OP_RTYPE: begin
                id_dec.wr = 1'b1;
                id_dec.u1 = 1'b1;
                id_dec.u2 = 1'b1;
            end
            OP_STYPE: begin
                id_dec.mem = 1'b1;
                id_dec.u1  = 1'b1;
                id_dec.u2  = 1'b1;
            end
            OP_BTYPE: begin
                id_dec.u1 = 1'b1;
                id_dec.u2 = 1'b1;
            end
            default: id_dec = '0;
        endcase
        if (id_dec.wr || id_dec.load || id_dec.mem || id_dec.u1 || id_dec.u2) begin
            id_dec.rd  = id_rd;
            id_dec.rs1 = id_rs1;
            id_dec.rs2 = id_rs2;
        end
        id_dec.wr = id_dec.wr && (id_rd != 5'd0);
    end

    assign load_use = id_valid && ex_q.load &&
                      ((id_dec.u1 && (id_rs1 == ex_q.rd)) ||
                       (id_dec.u2 && (id_rs2 == ex_q.rd)));

    // Freeze dominates: a taken branch seen while frozen is replayed once memory completes.
    assign freeze       = !rst && mem_q.mem && !dmem_ready;
    assign branch_act   = !rst && !freeze && ex_branch_taken;
    assign load_use_act = !rst && !freeze && !ex_branch_taken && load_use;

    assign stall_if  = freeze || load_use_act;
    assign stall_id  = freeze || load_use_act;
    assign bubble_ex = branch_act || load_use_act;
    assign flush_id  = branch_act;

    function automatic logic [1:0] fwd_pick(input logic [4:0]  rs,
                                            input logic        used,
                                            input mem_shadow_t m,
                                            input wb_shadow_t  w);
        logic [1:0] sel;
        sel = MUX_REG;
        if (used && (rs != 5'd0)) begin
            if (m.wr && !m.load && (m.rd == rs)) begin
                sel = MUX_MEM;
            end else if (w.wr && (w.rd == rs)) begin
                sel = MUX_WB;
            end
        end
        return sel;
    endfunction

    assign fwd_sel1 = rst ? MUX_REG : fwd_pick(ex_q.rs1, ex_q.u1, mem_q, wb_q);
    assign fwd_sel2 = rst ? MUX_REG : fwd_pick(ex_q.rs2, ex_q.u2, mem_q, wb_q);

    always_comb begin
        ex_nxt = id_dec;
        if (load_use || ex_branch_taken || !id_valid) begin
            ex_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!freeze) begin
            wb_q  <= '{rd: mem_q.rd, wr: mem_q.wr};
            mem_q <= '{rd: ex_q.rd, wr: ex_q.wr, load: ex_q.load, mem: ex_q.mem};
            ex_q  <= ex_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (mem_q.mem && !dmem_ready) state_nxt = MEM_WAIT;
            MEM_WAIT: if (dmem_ready)               state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_if && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (flush_id && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed vector bench for hazard_controller, counters narrowed to 4 bits so saturation is reachable.
module tb_hazard_controller;

    localparam int CW = 4;

    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_X = 7'b0000000;

    localparam logic [1:0] REG = 2'd0;
    localparam logic [1:0] MEM = 2'd1;
    localparam logic [1:0] WB  = 2'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [6:0]    id_opcode;
    logic [4:0]    id_rd, id_rs1, id_rs2;
    logic          ex_branch_taken;
    logic          dmem_ready;
    logic          stall_if, stall_id, bubble_ex, flush_id, freeze;
    logic [1:0]    fwd_sel1, fwd_sel2;
    logic [CW-1:0] stall_cycles, flush_count;

    int total = 0;
    int bad   = 0;

    hazard_controller #(.CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_opcode       (id_opcode),
        .id_rd           (id_rd),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_branch_taken (ex_branch_taken),
        .dmem_ready      (dmem_ready),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .bubble_ex       (bubble_ex),
        .flush_id        (flush_id),
        .freeze          (freeze),
        .fwd_sel1        (fwd_sel1),
        .fwd_sel2        (fwd_sel2),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          vld;
        logic [6:0]    op;
        logic [4:0]    rd;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic          br;
        logic          rdy;
        logic          e_stall;
        logic          e_bub;
        logic          e_flush;
        logic          e_frz;
        logic [1:0]    e_f1;
        logic [1:0]    e_f2;
        logic [CW-1:0] e_sc;
        logic [CW-1:0] e_fc;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_stall, input logic e_bub,
                           input logic e_flush, input logic e_frz, input logic [1:0] e_f1,
                           input logic [1:0] e_f2, input logic [CW-1:0] e_sc,
                           input logic [CW-1:0] e_fc);
        chk({tag, " stall_if"},     32'(stall_if),     32'(e_stall));
        chk({tag, " stall_id"},     32'(stall_id),     32'(e_stall));
        chk({tag, " bubble_ex"},    32'(bubble_ex),    32'(e_bub));
        chk({tag, " flush_id"},     32'(flush_id),     32'(e_flush));
        chk({tag, " freeze"},       32'(freeze),       32'(e_frz));
        chk({tag, " fwd_sel1"},     32'(fwd_sel1),     32'(e_f1));
        chk({tag, " fwd_sel2"},     32'(fwd_sel2),     32'(e_f2));
        chk({tag, " stall_cycles"}, 32'(stall_cycles), 32'(e_sc));
        chk({tag, " flush_count"},  32'(flush_count),  32'(e_fc));
    endtask

    initial begin
        //               vld  op    rd    rs1   rs2  br rdy st bu fl fz  f1   f2   sc    fc
        tbl[0]  = '{1'b1, OP_R, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0, 0, REG, REG, 4'd0, 4'd0};
        tbl[1]  = '{1'b1, OP_R, 5'd2, 5'd1, 5'd1, 0, 1, 0, 0, 0, 0, REG, REG, 4'd0, 4'd0};
        tbl[2]  = '{1'b1, OP_L, 5'd5, 5'd1, 5'd0, 0, 1, 0, 0, 0, 0, MEM, MEM, 4'd0, 4'd0};
        tbl[3]  = '{1'b1, OP_R, 5'd6, 5'd5, 5'd0, 0, 1, 1, 1, 0, 0, WB,  REG, 4'd0, 4'd0};
        tbl[4]  = '{1'b1, OP_R, 5'd6, 5'd5, 5'd0, 0, 1, 0, 0, 0, 0, REG, REG, 4'd1, 4'd0};
        tbl[5]  = '{1'b1, OP_L, 5'd7, 5'd6, 5'd0, 0, 1, 0, 0, 0, 0, WB,  REG, 4'd1, 4'd0};
        tbl[6]  = '{1'b1, OP_R, 5'd9, 5'd7, 5'd7, 1, 1, 0, 1, 1, 0, MEM, REG, 4'd1, 4'd0};
        tbl[7]  = '{1'b1, OP_I, 5'd0, 5'd0, 5'd1, 0, 1, 0, 0, 0, 0, REG, REG, 4'd1, 4'd1};
        tbl[8]  = '{1'b1, OP_R, 5'd3, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0, REG, REG, 4'd1, 4'd1};
        tbl[9]  = '{1'b0, OP_X, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0, REG, REG, 4'd1, 4'd1};
        tbl[10] = '{1'b1, OP_S, 5'd0, 5'd3, 5'd3, 0, 1, 0, 0, 0, 0, REG, REG, 4'd1, 4'd1};
        tbl[11] = '{1'b1, OP_R, 5'd4, 5'd1, 5'd2, 0, 1, 0, 0, 0, 0, WB,  WB,  4'd1, 4'd1};
        tbl[12] = '{1'b1, OP_R, 5'd4, 5'd1, 5'd2, 0, 0, 1, 0, 0, 1, REG, REG, 4'd1, 4'd1};
        tbl[13] = '{1'b1, OP_R, 5'd4, 5'd1, 5'd2, 1, 0, 1, 0, 0, 1, REG, REG, 4'd2, 4'd1};
        tbl[14] = '{1'b1, OP_R, 5'd4, 5'd1, 5'd2, 0, 0, 1, 0, 0, 1, REG, REG, 4'd3, 4'd1};
        tbl[15] = '{1'b1, OP_R, 5'd4, 5'd1, 5'd2, 1, 1, 0, 1, 1, 0, REG, REG, 4'd4, 4'd1};
        tbl[16] = '{1'b0, OP_X, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0, REG, REG, 4'd4, 4'd2};

        // Branch input held high during reset must not leak to flush_id.
        rst = 1'b1;
        id_valid = 1'b0; id_opcode = OP_X; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
        ex_branch_taken = 1'b1;
        dmem_ready = 1'b0;
        #7;
        chk_all("reset", 0, 0, 0, 0, REG, REG, 4'd0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        ex_branch_taken = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            id_valid        = tbl[i].vld;
            id_opcode       = tbl[i].op;
            id_rd           = tbl[i].rd;
            id_rs1          = tbl[i].rs1;
            id_rs2          = tbl[i].rs2;
            ex_branch_taken = tbl[i].br;
            dmem_ready      = tbl[i].rdy;
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_bub, tbl[i].e_flush,
                    tbl[i].e_frz, tbl[i].e_f1, tbl[i].e_f2, tbl[i].e_sc, tbl[i].e_fc);
        end

        // Store enters MEM, then memory stays busy long enough to saturate stall_cycles.
        @(negedge clk);
        id_valid = 1'b1; id_opcode = OP_S; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
        ex_branch_taken = 1'b0; dmem_ready = 1'b1;
        @(negedge clk);
        id_valid = 1'b0; id_opcode = OP_X;
        @(negedge clk);
        dmem_ready = 1'b0;
        #1;
        chk("sat start freeze", 32'(freeze), 32'd1);
        chk("sat start count", 32'(stall_cycles), 32'd4);
        repeat (13) @(posedge clk);
        #1;
        chk("sat reached", 32'(stall_cycles), 32'd15);
        chk("sat still stalling", 32'(stall_if), 32'd1);
        @(posedge clk);
        #1;
        chk("sat holds", 32'(stall_cycles), 32'd15);

        // Asynchronous reset in the middle of the memory wait.
        #2;
        rst = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        chk_all("midwait rst", 0, 0, 0, 0, REG, REG, 4'd0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        ex_branch_taken = 1'b0;
        dmem_ready = 1'b0;
        #1;
        chk_all("post rst", 0, 0, 0, 0, REG, REG, 4'd0, 4'd0);
        @(posedge clk);
        #1;
        chk("post rst count", 32'(stall_cycles), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
